// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned W_DEF    = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned BUS_MAX  = 64;

  // Extracts address field i (aw bits wide) from a flattened read-address bus.
  function automatic logic [15:0] rd_port_addr(input logic [BUS_MAX-1:0] bus,
                                               input int unsigned i,
                                               input int unsigned aw);
    logic [BUS_MAX-1:0] sh;
    sh = bus >> (i * aw);
    return 16'(sh & ((64'd1 << aw) - 64'd1));
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending scoreboard: issue sets, writeback clears, issue wins.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          iss_valid_i,
  input  logic [AW-1:0] iss_addr_i,
  input  logic          we0_i,
  input  logic [AW-1:0] wa0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] wa1_i,
  output logic [NREG-1:0] pend_o,
  output logic [AW:0]     pend_cnt_o
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     cnt_q, cnt_d;

  always_comb begin
    pend_d = pend_q;
    cnt_d  = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (iss_valid_i && iss_addr_i == AW'(r))
        pend_d[r] = 1'b1;
      else if ((we0_i && wa0_i == AW'(r)) || (we1_i && wa1_i == AW'(r)))
        pend_d[r] = 1'b0;
    end
    pend_d[REG_ZERO] = 1'b0;
    for (int unsigned r = 0; r < NREG; r++)
      cnt_d = cnt_d + (AW+1)'(pend_d[r]);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD read ports, two write ports, bypass, debug read, scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned AW     = $clog2(NREG),
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*W-1:0]  rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [W-1:0]    wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [W-1:0]    wd1,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   dbg_addr,
  output logic [W-1:0]    dbg_data,
  output logic [AW:0]     pend_cnt
);

  logic [W-1:0]       rf_q [NREG];
  logic [NREG-1:0]    pend;
  logic [BUS_MAX-1:0] rd_bus;
  logic [AW-1:0]      ra [NRD];

  rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .CLK        (CLK),
    .Reset      (Reset),
    .iss_valid_i(iss_valid),
    .iss_addr_i (iss_addr),
    .we0_i      (we0),
    .wa0_i      (wa0),
    .we1_i      (we1),
    .wa1_i      (wa1),
    .pend_o     (pend),
    .pend_cnt_o (pend_cnt)
  );

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned r = 0; r < NREG; r++) rf_q[r] <= '0;
    end else begin
      if (we0 && wa0 != AW'(REG_ZERO)) rf_q[wa0] <= wd0;
      if (we1 && wa1 != AW'(REG_ZERO)) rf_q[wa1] <= wd1;
    end
  end

  assign rd_bus = BUS_MAX'(rd_addr);

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++)
      ra[i] = AW'(rd_port_addr(rd_bus, i, AW));
  end

  // Bypass is gated by Reset so the read ports stay zero while reset is held.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (ra[i] != AW'(REG_ZERO)) begin
        if ((BYPASS != 0) && Reset && we1 && wa1 == ra[i])
          rd_data[i*W +: W] = wd1;
        else if ((BYPASS != 0) && Reset && we0 && wa0 == ra[i])
          rd_data[i*W +: W] = wd0;
        else
          rd_data[i*W +: W] = rf_q[ra[i]];
      end
      rd_busy[i] = pend[ra[i]] &&
                   !((BYPASS != 0) && ((we0 && wa0 == ra[i]) || (we1 && wa1 == ra[i])));
    end
  end

  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: bypassed and non-bypassed instances against a reference model.
module tb_regfile_mp;

  localparam int unsigned W = 32, NREG = 32, AW = 5, NRD = 2;

  logic CLK = 1'b0, Reset = 1'b0;
  logic [AW-1:0] ra0, ra1, wa0, wa1, iss_addr, dbg_addr;
  logic we0, we1, iss_valid;
  logic [W-1:0] wd0, wd1;
  logic [NRD*AW-1:0] rd_addr;

  logic [NRD*W-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]   rd_busy_b, rd_busy_n;
  logic [W-1:0]     dbg_data_b, dbg_data_n;
  logic [AW:0]      pend_cnt_b, pend_cnt_n;

  logic [W-1:0] mem [NREG];
  logic [NREG-1:0] pend_m;
  int total = 0, bad = 0;

  assign rd_addr = {ra1, ra0};

  always #5 CLK = ~CLK;

  regfile_mp #(.W(W), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut_b (
    .CLK(CLK), .Reset(Reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data_b), .pend_cnt(pend_cnt_b));

  regfile_mp #(.W(W), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut_n (
    .CLK(CLK), .Reset(Reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data_n), .pend_cnt(pend_cnt_n));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!Reset || a == 0) return '0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (!Reset) return 1'b0;
    return pend_m[a] && !(byp && ((we0 && wa0 == a) || (we1 && wa1 == a)));
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) mem[r] = '0;
    pend_m = '0;
  endtask

  task automatic check_all();
    chk("rd0_byp",   64'(rd_data_b[31:0]),  64'(exp_rd(ra0, 1'b1)));
    chk("rd1_byp",   64'(rd_data_b[63:32]), 64'(exp_rd(ra1, 1'b1)));
    chk("rd0_nobyp", 64'(rd_data_n[31:0]),  64'(exp_rd(ra0, 1'b0)));
    chk("rd1_nobyp", 64'(rd_data_n[63:32]), 64'(exp_rd(ra1, 1'b0)));
    chk("busy_byp",   64'(rd_busy_b), 64'({exp_busy(ra1, 1'b1), exp_busy(ra0, 1'b1)}));
    chk("busy_nobyp", 64'(rd_busy_n), 64'({exp_busy(ra1, 1'b0), exp_busy(ra0, 1'b0)}));
    chk("dbg_byp",   64'(dbg_data_b), 64'(mem[dbg_addr]));
    chk("dbg_nobyp", 64'(dbg_data_n), 64'(mem[dbg_addr]));
    chk("cnt_byp",   64'(pend_cnt_b), 64'($countones(pend_m)));
    chk("cnt_nobyp", 64'(pend_cnt_n), 64'($countones(pend_m)));
  endtask

  // Check combinational outputs, cross the edge, then advance the model.
  task automatic tick();
    #1 check_all();
    @(posedge CLK);
    if (Reset) begin
      if (we0 && wa0 != 0) mem[wa0] = wd0;
      if (we1 && wa1 != 0) mem[wa1] = wd1;
      for (int r = 1; r < NREG; r++) begin
        if (iss_valid && iss_addr == AW'(r)) pend_m[r] = 1'b1;
        else if ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r))) pend_m[r] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_valid = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_addr = 0;
  endtask

  initial begin
    idle(); ra0 = 0; ra1 = 0; dbg_addr = 0;
    model_clear();
    tick(); tick();
    Reset = 1'b1;
    tick();

    // Same-cycle write with bypass, debug port shows the old value.
    we0 = 1; wa0 = 5; wd0 = 32'h0000_A5A5; tick();
    wa0 = 5; wd0 = 32'hDEAD_BEEF; ra0 = 5; dbg_addr = 5;
    #1 chk("byp_deadbeef", 64'(rd_data_b[31:0]), 64'h0000_0000_DEAD_BEEF);
    chk("nobyp_old", 64'(rd_data_n[31:0]), 64'h0000_0000_0000_A5A5);
    tick();
    idle(); tick();

    // Dual write to one address: port 1 wins.
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra1 = 7; dbg_addr = 7;
    tick();
    idle();
    #1 chk("dual_wr_dbg", 64'(dbg_data_b), 64'h22);
    tick();

    // Register zero ignores writes and issues.
    we0 = 1; wa0 = 0; wd0 = 32'h1234; iss_valid = 1; iss_addr = 0; ra0 = 0; dbg_addr = 0;
    tick();
    idle(); tick();

    // Issue r3, then write it back.
    iss_valid = 1; iss_addr = 3; ra0 = 3; tick();
    idle(); we0 = 1; wa0 = 3; wd0 = 32'h3333;
    #1 chk("r3_busy_clr", 64'(rd_busy_b[0]), 64'd0);
    chk("r3_cnt_one", 64'(pend_cnt_b), 64'd1);
    tick();
    idle(); tick();

    // Issue and write of r9 in one cycle: issue is younger and wins.
    iss_valid = 1; iss_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h9999; ra1 = 9; tick();
    idle();
    #1 chk("r9_busy", 64'(rd_busy_b[1]), 64'd1);
    tick();

    // Randomised traffic concentrated on low addresses to force collisions.
    for (int n = 0; n < 400; n++) begin
      we0 = ($urandom_range(0, 1) == 1);
      we1 = ($urandom_range(0, 3) == 0);
      iss_valid = ($urandom_range(0, 2) == 0);
      wa0 = AW'($urandom_range(0, 15)); wa1 = AW'($urandom_range(0, 15));
      iss_addr = AW'($urandom_range(0, 15));
      wd0 = $urandom; wd1 = $urandom;
      ra0 = AW'($urandom_range(0, 15)); ra1 = AW'($urandom_range(0, 15));
      dbg_addr = AW'($urandom_range(0, 15));
      tick();
    end

    // Fill the scoreboard, then assert reset between edges.
    idle();
    for (int r = 1; r < NREG; r++) begin
      iss_valid = 1; iss_addr = AW'(r); tick();
    end
    idle(); ra0 = 5; ra1 = 7;
    #1 chk("cnt_full", 64'(pend_cnt_b), 64'd31);
    #2 Reset = 1'b0; we0 = 1; wa0 = 5; wd0 = 32'hFFFF_0000;
    model_clear();
    #1 chk("rst_rd0", 64'(rd_data_b[31:0]), 64'd0);
    chk("rst_cnt", 64'(pend_cnt_b), 64'd0);
    tick(); tick();
    idle(); Reset = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined MIPS core; successor to the single-write, three-read register file.
- Provides NRD read ports, two write ports (WB and late-commit paths), write-through bypass and a debug read port.
- Writes occur on the rising edge, so no half-cycle negedge write is needed.
- Holds a per-register pending scoreboard: decode marks a destination busy at issue and writeback clears it; hazard logic uses rd_busy to stall.

Parameters:
- W, 32, data width in bits.
- NREG, 32, number of registers (power of two, ≥2); register 0 is hardwired to zero.
- AW, $clog2(NREG), address width (derived; not overridden).
- NRD, 2, number of architectural read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value only.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*W  read data per port.
- rd_busy  out  NRD  pending flag of each read address, after same-cycle write clear.
- we0  in  1  write enable, port 0 (WB stage).
- wa0  in  AW  write address, port 0.
- wd0  in  W  write data, port 0.
- we1  in  1  write enable, port 1 (late commit, e.g. HI/LO-to-GPR or load return).
- wa1  in  AW  write address, port 1.
- wd1  in  W  write data, port 1.
- iss_valid  in  1  decode issues an instruction with a destination register.
- iss_addr  in  AW  destination to mark pending.
- dbg_addr  in  AW  debug/monitor read address.
- dbg_data  out  W  stored value at dbg_addr (no bypass).
- pend_cnt  out  AW+1  number of pending registers.

Behaviour:
Reset (Reset=0, asynchronous):
- All registers are 0 and all pending bits are 0.
- Outputs while in reset: rd_data=0, rd_busy=0, dbg_data=0, pend_cnt=0.
- Reset deasserts synchronously to CLK externally; no file load occurs.

Writes:
- At posedge, if weK=1 and waK≠0, then rf[waK] ← wdK.
- Writes to address 0 are discarded.
- If both ports write the same address in one cycle, port 1 wins.

Reads (combinational):
- Address 0 always returns 0.
- If BYPASS=1 and a write is active to rd_addr[i] (non-zero), rd_data[i] is the winning write data (port 1 over port 0).
- Otherwise rd_data[i] is rf[rd_addr[i]].
- dbg_data is always the stored value, never bypassed.

Scoreboard, per register r≠0, at each posedge:
- set = iss_valid & iss_addr==r.
- clr = (we0 & wa0==r) | (we1 & wa1==r).
- pend[r] ← set ? 1 : (clr ? 0 : pend[r]).
- An issue and a write to the same register in the same cycle leave it pending, because the issue is younger.
- Issue to r0 is ignored; pend[0] is constant 0.
- Re-issue to an already-pending register keeps it at 1; there is no counting per register.

Busy output:
- rd_busy[i] = pend[rd_addr[i]] & ~clr(rd_addr[i]) when BYPASS=1.
- rd_busy[i] = pend[rd_addr[i]] when BYPASS=0.
- Same-cycle iss_valid does not affect rd_busy.

pend_cnt:
- Registered population count of pend, updated each posedge.
- Equals the popcount of the new pend vector, so it is valid the cycle after the change.
- Maximum value is NREG-1.

Latency:
- Reads: 0 cycles (with bypass).
- Write visible to a non-bypassed read: 1 cycle.
- Pending set/clear: 1 cycle.

Decomposition:
- Shared package regfile_pkg:
  - default W/NREG constants;
  - REG_ZERO constant;
  - function to extract read port i from the flattened bus.
- Sub-module rf_scoreboard: pending vector, set/clear priority, pend_cnt popcount.
- The storage array, read muxes and bypass stay in regfile_mp.

Test Plan:
1. Reset low mid-run with pend=0xFFFF_FFFE, then release → all reads 0, rd_busy=0, pend_cnt=0 immediately, without waiting for a clock edge.
2. we0=1, wa0=5, wd0=0xDEADBEEF with rd_addr[0]=5 in the same cycle → rd_data[0]=0xDEADBEEF (BYPASS=1), dbg_data=old value until the next edge. With BYPASS=0 → rd_data[0]=old value.
3. we0 and we1 both write address 7 (0x11, 0x22) → after the edge rf[7]=0x22, and the bypassed read shows 0x22 in the same cycle.
4. Write 0x1234 to address 0, then read address 0 → 0. iss_addr=0 → pend_cnt stays 0.
5. Issue r3, the next cycle write r3 → rd_busy for r3 is 1 in cycle 1, 0 during the write cycle (BYPASS=1), and pend_cnt goes 1→0.
6. Simultaneous iss_valid on r9 and we0 on r9 → pend[9] stays 1, rd_busy on r9 is 1 the following cycle, and pend_cnt increments.
